pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
- Parametrised successor to the fixed per-stage pipeline registers (fetch->decode and similar).
- Generic stage register with a valid/ready handshake, a 2-entry skid buffer so back-pressure never forces a combinational ready path, and a stall input.
- Flush clears only selected bits of the payload; the remaining bits are retained.
- Saturating bubble counter for pipeline performance monitoring.
- Instantiated between any two pipeline stages; replaces hand-built per-stage register modules.

Parameters:
- DATA_W, 64, payload width (e.g. instr 32 + pc_plus_4 32).
- FLUSH_MASK, {DATA_W{1'b1}}. Payload bits set to 1 are zeroed on flush; bits set to 0 keep their value.
- RST_VAL, {DATA_W{1'b0}}, payload value loaded on reset.
- FLUSH_WHEN_STALL, 0. 0: flush ignored while stall=1 (legacy stage behaviour). 1: flush always takes effect.
- BUB_W, 16, bubble counter width.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous reset, active-low.
- stall  input  1  hold output side; downstream acceptance blocked.
- flush  input  1  kill stage contents.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept a payload.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream can accept.
- out_data  output  DATA_W  payload to next stage.
- occupancy  output  2  entries held (0, 1 or 2).
- bubble_cnt  output  BUB_W  saturating bubble count.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-low; it is sampled only on a clk rising edge.
- Reset (rst=0 at edge):
  - main_valid=0, skid_valid=0.
  - main_data=skid_data=RST_VAL; out_data=RST_VAL.
  - bubble_cnt=0; occupancy=0.
  - in_ready forced 0 while rst=0. Inputs are ignored in a reset cycle and nothing is accepted.
- Handshake definitions:
  - acc_in = in_valid & in_ready.
  - take = out_ready & ~stall.
  - acc_out = out_valid & take.
- Output and ready derivation:
  - out_valid = main_valid; out_data = main_data.
  - in_ready = ~skid_valid (registered state only; no combinational path from out_ready to in_ready).
- States and transitions, by {main_valid, skid_valid}:
  - EMPTY (0,0):
    - acc_in -> ONE; main_data <= in_data.
  - ONE (1,0):
    - acc_in & acc_out -> ONE; main_data <= in_data.
    - acc_in & ~acc_out -> FULL; skid_data <= in_data.
    - ~acc_in & acc_out -> EMPTY.
    - otherwise hold.
  - FULL (1,1):
    - acc_out -> ONE; main_data <= skid_data, skid cleared.
    - in_ready=0, so no input is accepted in FULL.
    - otherwise hold.
- Order and latency:
  - FIFO order preserved.
  - Latency 1 cycle: a payload accepted at edge N is visible on out_valid/out_data after edge N.
  - Sustained throughput 1 payload/cycle while take=1.
- Flush:
  - flush_eff = flush & (FLUSH_WHEN_STALL | ~stall).
  - When flush_eff=1:
    - main_valid<=0, skid_valid<=0.
    - main_data <= main_data & ~FLUSH_MASK.
    - skid_data unchanged (don't-care).
  - Flush beats simultaneous acc_in: that input is consumed (handshake completed) and discarded.
  - Flush beats simultaneous acc_out for state; the downstream still sees that transfer as completed that cycle.
- Stall:
  - take=0: no output transfer; state holds except for input filling.
  - Input still fills the skid entry until FULL.
- occupancy = main_valid + skid_valid.
- bubble_cnt:
  - Increments by 1 when take & ~out_valid & rst=1.
  - Saturates at all-ones; never wraps.
  - Cleared only by reset.
- Invariant: skid_valid=1 implies main_valid=1. Assertion required.

Test Plan:
- Reset then stream: in_valid=1 with data 1..8, out_ready=1, stall=0 -> out_data 1..8 on consecutive cycles starting one cycle after first accept; in_ready stays 1; occupancy 1.
- Back-pressure: stream A,B,C with out_ready=0 -> A,B accepted; in_ready=0 after B (occupancy=2); C held upstream. Raise out_ready -> A,B,C delivered in order, no loss or duplication.
- Partial flush: DATA_W=64, FLUSH_MASK=64'hFFFFFFFF_00000000, main=64'h12345678_00400004, flush=1 -> out_valid=0, out_data=64'h00000000_00400004, occupancy=0.
- Flush during stall:
  - FLUSH_WHEN_STALL=0, stall=1, flush=1 -> contents and out_valid unchanged.
  - FLUSH_WHEN_STALL=1, same stimulus -> cleared as in the partial-flush case.
- Simultaneous flush and accept: in ONE state, in_valid=1, flush=1 -> next cycle occupancy=0; the new payload never appears at output.
- Reset mid-operation and bubble saturation:
  - In FULL, rst=0 for one edge -> all outputs at reset values; in_ready=0 during that cycle.
  - BUB_W=4, out_ready=1, no input for 20 cycles -> bubble_cnt reaches 15 and holds.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Generic pipeline stage register with a valid/ready handshake, a two-entry skid buffer,
// a masked flush and a saturating bubble counter.
//
// state | meaning
// EMPTY | {main_valid,skid_valid}=00, nothing held
// ONE   | 10, one payload in main, presented downstream
// FULL  | 11, main presented, skid holds the next payload; upstream blocked
module pipe_skid_reg #(
  parameter int                DATA_W           = 64,
  parameter logic [DATA_W-1:0] FLUSH_MASK       = {DATA_W{1'b1}},
  parameter logic [DATA_W-1:0] RST_VAL          = {DATA_W{1'b0}},
  parameter bit                FLUSH_WHEN_STALL = 1'b0,
  parameter int                BUB_W            = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [BUB_W-1:0]  bubble_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [BUB_W-1:0]  bub_q,        bub_d;

  logic acc_in;
  logic take;
  logic acc_out;
  logic flush_eff;

  // in_ready depends only on registered state (and reset), never on out_ready
  assign in_ready   = rst & ~skid_valid_q;
  assign acc_in     = in_valid & in_ready;
  assign take       = out_ready & ~stall;
  assign acc_out    = main_valid_q & take;
  assign flush_eff  = flush & (FLUSH_WHEN_STALL | ~stall);

  assign out_valid  = main_valid_q;
  assign out_data   = main_data_q;
  assign occupancy  = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign bubble_cnt = bub_q;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush_eff) begin
      // flush wins over any same-cycle accept; masked-off bits survive
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_data_d  = main_data_q & ~FLUSH_MASK;
    end else begin
      case ({main_valid_q, skid_valid_q})
        ST_EMPTY: begin
          if (acc_in) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
          end
        end
        ST_ONE: begin
          if (acc_in && acc_out) begin
            main_data_d = in_data;
          end else if (acc_in) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
          end else if (acc_out) begin
            main_valid_d = 1'b0;
          end
        end
        ST_FULL: begin
          if (acc_out) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bub_d = bub_q;
    if (take && !main_valid_q && !(&bub_q)) begin
      bub_d = bub_q + {{(BUB_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= RST_VAL;
      skid_data_q  <= RST_VAL;
      bub_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      bub_q        <= bub_d;
    end
  end

  a_skid_implies_main: assert property (@(posedge clk) disable iff (!rst)
    skid_valid_q |-> main_valid_q);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: two instances (flush ignored / honoured under stall) checked
// every cycle against a queue-level model, plus directed literal checks.
module tb_pipe_skid_reg;
  localparam logic [63:0] MASK = 64'hFFFFFFFF_00000000;
  localparam logic [63:0] RV   = 64'h00000000_5A5AA5A5;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid, out_ready;
  logic [63:0] in_data;
  logic [1:0]  ir, ov;
  logic [63:0] od0, od1;
  logic [1:0]  occ0, occ1;
  logic [3:0]  bub0, bub1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(64), .FLUSH_MASK(MASK), .RST_VAL(RV),
                  .FLUSH_WHEN_STALL(1'b0), .BUB_W(4)) u0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od0),
    .occupancy(occ0), .bubble_cnt(bub0));

  pipe_skid_reg #(.DATA_W(64), .FLUSH_MASK(MASK), .RST_VAL(RV),
                  .FLUSH_WHEN_STALL(1'b1), .BUB_W(4)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od1),
    .occupancy(occ1), .bubble_cnt(bub1));

  // Model: a FIFO of up to two payloads plus the last value seen at the head.
  logic [63:0] m_buf   [2][2];
  int          m_n     [2];
  logic [63:0] m_stale [2];
  int          m_bub   [2];
  bit          armed = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        m_n[i] = 0; m_stale[i] = RV; m_bub[i] = 0;
        armed = 1'b1;
      end else begin
        bit ai, tk, ao, fe;
        ai = in_valid && (m_n[i] < 2);
        tk = out_ready && !stall;
        ao = (m_n[i] > 0) && tk;
        fe = flush && ((i == 1) || !stall);
        if (tk && m_n[i] == 0 && m_bub[i] < 15) m_bub[i]++;
        if (fe) begin
          m_n[i] = 0;
          m_stale[i] = m_stale[i] & ~MASK;
        end else begin
          if (ao) begin
            m_buf[i][0] = m_buf[i][1];
            m_n[i]--;
          end
          if (ai) begin
            m_buf[i][m_n[i]] = in_data;
            m_n[i]++;
          end
          if (m_n[i] > 0) m_stale[i] = m_buf[i][0];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic v, input logic r, input logic [63:0] d,
                          input logic [1:0] oc, input logic [3:0] b);
    chk($sformatf("u%0d.out_valid", i), {63'd0, v}, {63'd0, m_n[i] > 0});
    chk($sformatf("u%0d.in_ready", i), {63'd0, r}, {63'd0, rst && m_n[i] < 2});
    chk($sformatf("u%0d.out_data", i), d, m_stale[i]);
    chk($sformatf("u%0d.occupancy", i), {62'd0, oc}, 64'(m_n[i]));
    chk($sformatf("u%0d.bubble_cnt", i), {60'd0, b}, 64'(m_bub[i]));
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp_inst(0, ov[0], ir[0], od0, occ0, bub0);
      cmp_inst(1, ov[1], ir[1], od1, occ1, bub1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic ordy,
                       input logic st, input logic fl);
    in_valid = v; in_data = d; out_ready = ordy; stall = st; flush = fl;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b1, 64'hFFFF, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    chk("reset out_valid", {63'd0, ov[0]}, 64'd0);
    chk("reset in_ready", {62'd0, ir}, 64'd0);
    chk("reset out_data", od0, RV);
    chk("reset bubble", {60'd0, bub0}, 64'd0);

    // Stream 1..8 at full rate
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 64'(k), 1'b1, 1'b0, 1'b0);
      tick();
      chk("stream out_data", od0, 64'(k));
      chk("stream occupancy", {62'd0, occ0}, 64'd1);
      chk("stream in_ready", {63'd0, ir[0]}, 64'd1);
    end
    drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    tick();

    // Back-pressure: A,B fill the stage, C waits upstream
    drive(1'b1, 64'hA, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 64'hB, 1'b0, 1'b0, 1'b0); tick();
    chk("bp occupancy full", {62'd0, occ0}, 64'd2);
    chk("bp in_ready low", {63'd0, ir[0]}, 64'd0);
    drive(1'b1, 64'hC, 1'b0, 1'b0, 1'b0); tick(); tick();
    chk("bp held out_data", od0, 64'hA);
    drive(1'b1, 64'hC, 1'b1, 1'b0, 1'b0); tick();
    chk("bp drain B", od0, 64'hB);
    tick();
    chk("bp drain C", od0, 64'hC);
    drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0); tick();
    chk("bp empty", {62'd0, occ0}, 64'd0);

    // Partial flush
    drive(1'b1, 64'h12345678_00400004, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b1); tick();
    chk("pflush out_valid", {63'd0, ov[0]}, 64'd0);
    chk("pflush out_data", od0, 64'h00000000_00400004);
    chk("pflush occupancy", {62'd0, occ0}, 64'd0);

    // Flush under stall: ignored by u0, honoured by u1
    drive(1'b1, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 64'd0, 1'b1, 1'b1, 1'b1); tick();
    chk("stflush u0 valid", {63'd0, ov[0]}, 64'd1);
    chk("stflush u0 data", od0, 64'hDEADBEEF_CAFEF00D);
    chk("stflush u1 valid", {63'd0, ov[1]}, 64'd0);
    chk("stflush u1 data", od1, 64'h00000000_CAFEF00D);
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b1); tick();

    // Flush together with an accept in ONE
    drive(1'b1, 64'h1111, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 64'h2222, 1'b0, 1'b0, 1'b1); tick();
    chk("flush+acc occupancy", {62'd0, occ0}, 64'd0);
    drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush+acc no output", {63'd0, ov[0]}, 64'd0);
    end

    // Reset from FULL
    drive(1'b1, 64'h3333, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 64'h4444, 1'b0, 1'b0, 1'b0); tick();
    chk("full before reset", {62'd0, occ0}, 64'd2);
    rst = 1'b0;
    drive(1'b1, 64'h5555, 1'b1, 1'b0, 1'b0);
    #1;
    chk("in_ready during reset", {62'd0, ir}, 64'd0);
    tick();
    chk("post-reset out_valid", {63'd0, ov[0]}, 64'd0);
    chk("post-reset out_data", od0, RV);
    chk("post-reset occupancy", {62'd0, occ0}, 64'd0);
    chk("post-reset bubble", {60'd0, bub0}, 64'd0);
    rst = 1'b1;

    // Bubble saturation
    drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) tick();
    chk("bubble sat u0", {60'd0, bub0}, 64'd15);
    chk("bubble sat u1", {60'd0, bub1}, 64'd15);

    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 3) != 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0);
      tick();
    end
    rst = 1'b1;
    drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
